// File: rtl/ioctl_stream_loader_pkg.sv
// Shared types and constants for the ioctl stream loader.
package ioctl_loader_pkg;

    localparam int unsigned DEF_ADDR_W = 25;
    localparam int unsigned CKSUM_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        WRITE,
        GAP,
        TAIL
    } loader_state_e;

endpackage

// File: rtl/ioctl_stream_loader_cycle_timer.sv
// Loadable down-counter with a zero flag; paces SETUP, GAP and TAIL.
module ioctl_cycle_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ioctl_stream_loader.sv
// MiSTer-style ioctl download initiator fed by a valid/ready byte stream.
// Optional `checksum` output when IOCTL_STREAM_LOADER_CHECKSUM_EN is defined.
module ioctl_stream_loader
    import ioctl_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        start_index,
    input  logic [ADDR_W-1:0] start_len,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
    ,
    output logic [CKSUM_W-1:0] checksum
`endif
);

    localparam int unsigned TMR_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);

    loader_state_e     state;
    logic [ADDR_W-1:0] remaining;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    ioctl_cycle_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Abort masks s_ready so that no byte is handshaken once abort is seen.
    assign s_ready = (state == FETCH) && !abort;

    // Timer is loaded on entry to each timed state, i.e. alongside the FSM transition.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (abort || (tmr_zero && (remaining == '0))) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            FETCH: begin
                if (abort) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
            end
            WRITE: begin
                tmr_load = 1'b1;
                tmr_val  = abort ? SETUP_LOAD : GAP_LOAD;
            end
            GAP: begin
                if (abort || (tmr_zero && !ioctl_wait && (remaining == '0))) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            TAIL: begin
                if (ioctl_wait) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            remaining      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_index    <= '0;
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            done     <= 1'b0;
            ioctl_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ioctl_index    <= start_index;
                        remaining      <= start_len;
                        ioctl_addr     <= '0;
                        aborted        <= 1'b0;
                        busy           <= 1'b1;
                        ioctl_download <= 1'b1;
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
                        checksum       <= '0;
`endif
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= TAIL;
                    end else if (tmr_zero) begin
                        state <= (remaining != '0) ? FETCH : TAIL;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= TAIL;
                    end else if (s_valid) begin
                        ioctl_dout <= s_data;
                        ioctl_wr   <= 1'b1;
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
                        checksum   <= checksum + CKSUM_W'(s_data);
`endif
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    remaining <= remaining - ADDR_W'(1);
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= TAIL;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= TAIL;
                    end else if (tmr_zero && !ioctl_wait) begin
                        if (remaining == '0) begin
                            state <= TAIL;
                        end else begin
                            ioctl_addr <= ioctl_addr + ADDR_W'(1);
                            state      <= FETCH;
                        end
                    end
                end
                TAIL: begin
                    if (!ioctl_wait && tmr_zero) begin
                        ioctl_download <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_stream_loader.sv
// Scoreboard bench for ioctl_stream_loader; checks checksum too when
// IOCTL_STREAM_LOADER_CHECKSUM_EN is defined.
module tb_ioctl_stream_loader;

    localparam int unsigned ADDR_W    = 25;
    localparam int unsigned SETUP_CYC = 4;
    localparam int unsigned GAP_CYC   = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } exp_t;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        start_index;
    logic [ADDR_W-1:0] start_len;
    logic              abort;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    ioctl_stream_loader #(
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (SETUP_CYC),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (start),
        .start_index    (start_index),
        .start_len      (start_len),
        .abort          (abort),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait)
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    bit         toggle_mode;

    int vectors;
    int miscompares;
    int cyc;
    int wr_cnt, done_cnt, dl_cycles, hs_cnt;
    int start_cyc, first_wr_cyc, last_wr_cyc, last_period;
    bit first_pending;

    int wr0, dn0, dl0, hs0;
    int fall_cyc;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic snap();
        wr0 = wr_cnt;
        dn0 = done_cnt;
        dl0 = dl_cycles;
        hs0 = hs_cnt;
    endtask

    task automatic start_xfer(input logic [7:0] idx, input logic [ADDR_W-1:0] len);
        start       = 1'b1;
        start_index = idx;
        start_len   = len;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == dn0 && n < 3000) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        if (done_cnt == dn0) $display("FAIL done_timeout: got no done, expected done pulse");
        tick();
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_cnt < target && n < 3000) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("wr_wait_bound", 40'(wr_cnt >= target), 40'(1));
    endtask

    task automatic load_bytes(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) src_q.push_back(b[i]);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        wr_cnt = 0; done_cnt = 0; dl_cycles = 0; hs_cnt = 0;
        start_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0; last_period = 0;
        first_pending = 1'b0; toggle_mode = 1'b0;
        reset_n = 1'b0; start = 1'b0; start_index = '0; start_len = '0;
        abort = 1'b0; s_valid = 1'b0; s_data = '0; ioctl_wait = 1'b0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk_sys);
                    cyc++;
                    if (start) begin
                        start_cyc     = cyc;
                        first_pending = 1'b1;
                    end
                    if (ioctl_download) dl_cycles++;
                    if (done) done_cnt++;
                    if (ioctl_wr) begin
                        if (first_pending) begin
                            first_wr_cyc  = cyc;
                            first_pending = 1'b0;
                        end
                        last_period = cyc - last_wr_cyc;
                        last_wr_cyc = cyc;
                        wr_cnt++;
                        check("wr_while_wait", 40'(ioctl_wait), 40'(0));
                        check("wr_expected", 40'(exp_q.size() != 0), 40'(1));
                        if (exp_q.size() != 0) begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("wr_addr_data", 40'({ioctl_addr, ioctl_dout}), 40'({e.addr, e.data}));
                        end
                    end
                end
            end
            begin : source
                bit hs;
                forever begin
                    @(negedge clk_sys);
                    hs = s_valid && s_ready;
                    if (hs) hs_cnt++;
                    @(posedge clk_sys);
                    #1;
                    if (hs && src_q.size() != 0) void'(src_q.pop_front());
                    if (src_q.size() != 0 && (!toggle_mode || $urandom_range(0, 1) == 1)) begin
                        s_valid = 1'b1;
                        s_data  = src_q[0];
                    end else begin
                        s_valid = 1'b0;
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) tick();
        check("rst_download", 40'(ioctl_download), 40'(0));
        check("rst_wr",       40'(ioctl_wr), 40'(0));
        check("rst_busy",     40'(busy), 40'(0));
        check("rst_done",     40'(done), 40'(0));
        check("rst_aborted",  40'(aborted), 40'(0));
        check("rst_addr",     40'(ioctl_addr), 40'(0));
        check("rst_dout",     40'(ioctl_dout), 40'(0));
        check("rst_index",    40'(ioctl_index), 40'(0));
        check("rst_s_ready",  40'(s_ready), 40'(0));
        reset_n = 1'b1;
        repeat (2) tick();

        // Test 1: len=4, A0..A3, no wait
        load_bytes('{8'hA0, 8'hA1, 8'hA2, 8'hA3});
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: ADDR_W'(i), data: 8'hA0 + 8'(i)});
        tick();
        snap();
        start_xfer(8'h00, 25'd4);
        check("t1_busy", 40'(busy), 40'(1));
        wait_done();
        check("t1_wr_count", 40'(wr_cnt - wr0), 40'(4));
        check("t1_done_count", 40'(done_cnt - dn0), 40'(1));
        // SETUP(4) + 4 x (FETCH + WRITE + GAP(2)) + TAIL(4); final GAP feeds TAIL directly
        check("t1_download_len", 40'(dl_cycles - dl0), 40'(24));
        check("t1_first_latency", 40'(first_wr_cyc - start_cyc), 40'(SETUP_CYC + 2));
        check("t1_period", 40'(last_period), 40'(GAP_CYC + 2));
        check("t1_busy_after", 40'(busy), 40'(0));
        check("t1_last_addr", 40'(ioctl_addr), 40'(3));
`ifdef IOCTL_STREAM_LOADER_CHECKSUM_EN
        check("t1_checksum", 40'(checksum), 40'(16'h0286));
`endif

        // Test 2: len=0, idx=0x05
        snap();
        start_xfer(8'h05, 25'd0);
        check("t2_index", 40'(ioctl_index), 40'(8'h05));
        wait_done();
        check("t2_wr_count", 40'(wr_cnt - wr0), 40'(0));
        check("t2_download_len", 40'(dl_cycles - dl0), 40'(2 * SETUP_CYC));
        check("t2_done_count", 40'(done_cnt - dn0), 40'(1));

        // Test 3: len=3, ioctl_wait held 20 cycles after the first strobe
        load_bytes('{8'h11, 8'h22, 8'h33});
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: ADDR_W'(i), data: 8'h11 * 8'(i + 1)});
        tick();
        snap();
        start_xfer(8'h07, 25'd3);
        wait_wr(wr0 + 1);
        tick();
        ioctl_wait = 1'b1;
        repeat (20) tick();
        ioctl_wait = 1'b0;
        fall_cyc = cyc + 1;
        check("t3_no_wr_during_wait", 40'(wr_cnt - wr0), 40'(1));
        wait_wr(wr0 + 2);
        check("t3_second_after_fall", 40'(last_wr_cyc >= fall_cyc), 40'(1));
        wait_done();
        check("t3_wr_count", 40'(wr_cnt - wr0), 40'(3));

        // Test 4: len=16 with s_valid toggling
        toggle_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(8'h5A ^ 8'(i));
            exp_q.push_back('{addr: ADDR_W'(i), data: 8'h5A ^ 8'(i)});
        end
        tick();
        snap();
        start_xfer(8'h10, 25'd16);
        wait_done();
        check("t4_wr_count", 40'(wr_cnt - wr0), 40'(16));
        check("t4_handshakes", 40'(hs_cnt - hs0), 40'(16));
        check("t4_done_count", 40'(done_cnt - dn0), 40'(1));
        check("t4_queue_empty", 40'(exp_q.size()), 40'(0));
        toggle_mode = 1'b0;

        // Test 5: abort after the 2nd strobe of len=8
        for (int i = 0; i < 8; i++) src_q.push_back(8'h80 + 8'(i));
        for (int i = 0; i < 2; i++) exp_q.push_back('{addr: ADDR_W'(i), data: 8'h80 + 8'(i)});
        tick();
        snap();
        start_xfer(8'h20, 25'd8);
        wait_wr(wr0 + 2);
        tick();
        abort = 1'b1;
        wait_done();
        abort = 1'b0;
        src_q.delete();
        repeat (2) tick();
        check("t5_wr_count", 40'(wr_cnt - wr0), 40'(2));
        check("t5_handshakes", 40'(hs_cnt - hs0), 40'(2));
        check("t5_aborted", 40'(aborted), 40'(1));
        check("t5_done_count", 40'(done_cnt - dn0), 40'(1));
        snap();
        start_xfer(8'h33, 25'd0);
        check("t5_aborted_cleared", 40'(aborted), 40'(0));
        wait_done();

        // Test 6: reset pulsed low mid-GAP, then a fresh transfer
        load_bytes('{8'hB0, 8'hB1, 8'hB2, 8'hB3});
        exp_q.push_back('{addr: ADDR_W'(0), data: 8'hB0});
        tick();
        snap();
        start_xfer(8'h40, 25'd4);
        wait_wr(wr0 + 1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_download_async", 40'(ioctl_download), 40'(0));
        check("t6_busy_async", 40'(busy), 40'(0));
        exp_q.delete();
        src_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("t6_addr_after_reset", 40'(ioctl_addr), 40'(0));
        load_bytes('{8'hC5, 8'hC6});
        exp_q.push_back('{addr: ADDR_W'(0), data: 8'hC5});
        exp_q.push_back('{addr: ADDR_W'(1), data: 8'hC6});
        tick();
        snap();
        start_xfer(8'h41, 25'd2);
        wait_done();
        check("t6_wr_count", 40'(wr_cnt - wr0), 40'(2));
        check("t6_done_count", 40'(done_cnt - dn0), 40'(1));
        check("t6_queue_empty", 40'(exp_q.size()), 40'(0));

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ioctl_stream_loader.md
Name: ioctl_stream_loader

Overview:
- Initiator side of the MiSTer-style ioctl download interface, the counterpart to the `ioctl_*` inputs consumed by the emu top.
- Accepts a transfer command (index, byte length) and a valid/ready byte stream from the Verilator harness or an on-chip ROM source.
- Emits `ioctl_download`, single-cycle `ioctl_wr` strobes, an incrementing `ioctl_addr` and `ioctl_dout`, and honours `ioctl_wait` back-pressure.
- Loads ROM/data images into `system` without C++-side cycle bookkeeping.

Parameters:
- ADDR_W, 25, width of `ioctl_addr` and of the length field.
- SETUP_CYC, 4, cycles `ioctl_download` is high before the first `ioctl_wr`, and also after the last one before it drops.
- GAP_CYC, 2, minimum idle cycles between consecutive `ioctl_wr` strobes (≥1).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe, accepted only in IDLE
- start_index  in  8  transfer index, latched on accepted start
- start_len  in  ADDR_W  byte count, latched on accepted start
- abort  in  1  level; terminates an active transfer
- s_valid  in  1  source byte valid
- s_data  in  8  source byte
- s_ready  out  1  byte consumed this cycle (s_valid & s_ready)
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE
- aborted  out  1  sticky: last transfer ended by abort; cleared on next accepted start
- ioctl_download  out  1  transfer window
- ioctl_wr  out  1  one-cycle write strobe
- ioctl_addr  out  ADDR_W  byte address, 0-based
- ioctl_dout  out  8  byte data, valid with ioctl_wr
- ioctl_index  out  8  latched index, stable for the whole window
- ioctl_wait  in  1  receiver stall request

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- All outputs are registered; `s_ready` is combinational only from state (FETCH) and is not gated by `s_valid`.
- IDLE: on `start`, latch index/len, clear `aborted`, then go to SETUP. `start` in any other state is ignored.
- SETUP: `ioctl_download`=1; count SETUP_CYC cycles. Then go to FETCH if len≠0, else to TAIL.
- FETCH: `s_ready`=1. On `s_valid`, register the byte into `ioctl_dout` and go to WRITE.
- WRITE: `ioctl_wr`=1 for exactly one cycle at the current `ioctl_addr`. Decrement remaining. Go to GAP.
- GAP: wait GAP_CYC cycles, then additionally wait while `ioctl_wait`=1.
  - `ioctl_addr` increments on the GAP→next transition.
  - If remaining=0, go to TAIL instead; the address does not increment past the last byte.
  - A `ioctl_wait` already high during GAP extends GAP; no strobe is issued while `ioctl_wait`=1.
- TAIL: wait until `ioctl_wait`=0, then count SETUP_CYC cycles. Drop `ioctl_download`, pulse `done`, go to IDLE.
- `ioctl_addr` resets to 0 on every accepted start. `ioctl_dout` holds its last value outside WRITE.
- Abort:
  - In SETUP/FETCH/GAP: set `aborted`, go to TAIL.
  - In WRITE: the strobe completes, then go to TAIL.
  - No byte is consumed after abort is seen.
- len = 2^ADDR_W−1: must complete; the remaining counter is ADDR_W wide with no wrap.
- `reset_n` low mid-transfer: `ioctl_download` and `ioctl_wr` drop immediately (asynchronously). The receiver sees a truncated download; this is acceptable.
- Latency: the first `ioctl_wr` occurs SETUP_CYC+2 cycles after `start`, given `s_valid` is high. Byte-to-byte period is GAP_CYC+2 cycles with no wait and a constant `s_valid`.

Optional Feature:
- Macro: IOCTL_STREAM_LOADER_CHECKSUM_EN.
- With the macro:
  - Extra output `checksum` (16 bits) holds the modulo-2^16 sum of every byte strobed with `ioctl_wr`.
  - Cleared on accepted start; valid when `done` pulses.
- Without it: the port and adder are absent.

Decomposition:
- Package `ioctl_loader_pkg` holds:
  - state enum {IDLE, SETUP, FETCH, WRITE, GAP, TAIL};
  - the default ADDR_W constant;
  - the checksum width constant.
- One sub-module, `ioctl_cycle_timer`: a loadable down-counter with a zero flag, shared by SETUP, GAP and TAIL timing.

Test Plan:
- start idx=0x00, len=4, bytes A0..A3, no wait:
  - exactly 4 `ioctl_wr` pulses at addr 0..3 with data A0..A3;
  - `done` pulses once; `ioctl_download` lasts 2·SETUP_CYC + 4·(GAP_CYC+2) + 1 cycles (±1 documented);
  - checksum = 0x0286 with the macro.
- len=0, idx=0x05 → `ioctl_download` high for 2·SETUP_CYC cycles; zero `ioctl_wr`; `done` pulses.
- len=3; hold `ioctl_wait`=1 for 20 cycles after the 1st strobe → 2nd strobe not earlier than wait fall + 0 cycles; addresses 0,1,2; no strobe while wait is high.
- `s_valid` toggled pseudo-randomly over len=16 → data order preserved; every `s_valid`&`s_ready` handshake produces exactly one strobe.
- abort asserted after the 2nd strobe of len=8 → exactly 2 strobes; `aborted`=1; `done` pulses; a subsequent start clears `aborted`.
- `reset_n` pulsed low mid-GAP → `ioctl_download`=0 and `busy`=0 immediately; a fresh start then restarts at addr 0.
